otp_session_ctrl: RTL and testbench

Session sequencer for the OTP authentication path. It captures a 16-bit word from the free-running LFSR on request and collects four user nibbles. It compares the entry against the captured OTP and enforces the validity window, the attempt limit and the lockout. It sits between the LFSR/button inputs and the 7-segment display driver, and supplies the captured OTP, the live entry and the status flags.

---
 rtl/otp_session_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_otp_session_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_session_ctrl.sv
// otp_session_ctrl: captures an OTP from the LFSR, collects four user nibbles, compares, and enforces expiry/attempts/lockout.
// Optional feature macro LOCKOUT_BACKOFF_EN: lockout length doubles per consecutive lockout (up to 8x).
module otp_session_ctrl #(
  parameter int unsigned EXPIRY_CYCLES  = 50000000,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCKOUT_CYCLES = 100000000,
  parameter int unsigned UNLOCK_CYCLES  = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] lfsr_word,
  input  logic        otp_req,
  input  logic [3:0]  user_digit,
  input  logic        user_latch,
  output logic [15:0] otp_out,
  output logic [15:0] user_otp_out,
  output logic        otp_valid,
  output logic        unlock,
  output logic        expired,
  output logic        locked,
  output logic [3:0]  attempts_left,
  output logic        sys_clr,
  output logic [2:0]  state_dbg
);

  // Input protocol: otp_req and user_latch are levels. Only a 0->1 transition sampled on a
  // clock edge acts; a held level acts once. There is no ready/backpressure: in states
  // where an input is ignored its edge is consumed and discarded.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_COMPARE  = 3'd2,
    S_UNLOCKED = 3'd3,
    S_LOCKOUT  = 3'd4,
    S_EXPIRED  = 3'd5
  } state_t;

`ifdef LOCKOUT_BACKOFF_EN
  localparam logic [63:0] LOCK_MAX = 64'(LOCKOUT_CYCLES) << 3;
`else
  localparam logic [63:0] LOCK_MAX = 64'(LOCKOUT_CYCLES);
`endif
  localparam logic [63:0] DUR_A   = (64'(EXPIRY_CYCLES) > 64'(UNLOCK_CYCLES)) ?
                                    64'(EXPIRY_CYCLES) : 64'(UNLOCK_CYCLES);
  localparam logic [63:0] DUR_MAX = (LOCK_MAX > DUR_A) ? LOCK_MAX : DUR_A;
  localparam int          TW      = $clog2(DUR_MAX + 64'd1);

  localparam logic [TW-1:0] EXP_LOAD = TW'(EXPIRY_CYCLES - 32'd1);
  localparam logic [TW-1:0] UNL_LOAD = TW'(UNLOCK_CYCLES - 32'd1);
  localparam logic [3:0]    ATT_MAX  = 4'(MAX_ATTEMPTS);

  state_t        state;
  logic [TW-1:0] timer;
  logic [1:0]    dig_cnt;
  logic          req_q;
  logic          latch_q;
  logic          edge_en;
  logic          req_rise;
  logic          latch_rise;
  logic          timer_done;
  logic          match;
  logic [TW-1:0] lock_load;

  // edge_en stays low for the first clock after reset so a level already high at
  // release is absorbed into req_q/latch_q instead of being seen as an edge.
  assign req_rise   = otp_req & ~req_q & edge_en;
  assign latch_rise = user_latch & ~latch_q & edge_en;
  assign timer_done = (timer == '0);
  assign match      = (user_otp_out == otp_out);
  assign state_dbg  = state;

`ifdef LOCKOUT_BACKOFF_EN
  logic [1:0] backoff_n;
  assign lock_load = TW'((64'(LOCKOUT_CYCLES) << backoff_n) - 64'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      backoff_n <= 2'd0;
    end else if (state == S_COMPARE && !timer_done && match) begin
      backoff_n <= 2'd0;
    end else if (state == S_LOCKOUT && timer_done && backoff_n != 2'd3) begin
      backoff_n <= backoff_n + 2'd1;
    end
  end
`else
  assign lock_load = TW'(LOCKOUT_CYCLES - 32'd1);
`endif

  // Flag vector {otp_valid, unlock, expired, locked} for a given state.
  function automatic logic [3:0] flags_of(input state_t s);
    case (s)
      S_ARMED, S_COMPARE: flags_of = 4'b1000;
      S_UNLOCKED:         flags_of = 4'b0100;
      S_EXPIRED:          flags_of = 4'b0010;
      S_LOCKOUT:          flags_of = 4'b0001;
      default:            flags_of = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      otp_out       <= '0;
      user_otp_out  <= '0;
      dig_cnt       <= '0;
      timer         <= '0;
      attempts_left <= ATT_MAX;
      sys_clr       <= 1'b0;
      req_q         <= 1'b0;
      latch_q       <= 1'b0;
      edge_en       <= 1'b0;
      {otp_valid, unlock, expired, locked} <= 4'b0000;
    end else begin
      req_q   <= otp_req;
      latch_q <= user_latch;
      edge_en <= 1'b1;
      sys_clr <= 1'b0;
      case (state)
        S_IDLE, S_EXPIRED: begin
          if (req_rise) begin
            otp_out      <= lfsr_word;
            user_otp_out <= '0;
            dig_cnt      <= '0;
            timer        <= EXP_LOAD;
            state        <= S_ARMED;
            {otp_valid, unlock, expired, locked} <= flags_of(S_ARMED);
          end
        end
        S_ARMED: begin
          // Expiry outranks both a re-capture and a final digit on the same edge.
          if (timer_done) begin
            state <= S_EXPIRED;
            {otp_valid, unlock, expired, locked} <= flags_of(S_EXPIRED);
          end else if (req_rise) begin
            otp_out      <= lfsr_word;
            user_otp_out <= '0;
            dig_cnt      <= '0;
            timer        <= EXP_LOAD;
          end else begin
            timer <= timer - 1'b1;
            if (latch_rise) begin
              user_otp_out <= {user_otp_out[11:0], user_digit};
              dig_cnt      <= dig_cnt + 2'd1;
              if (dig_cnt == 2'd3) begin
                state <= S_COMPARE;
              end
            end
          end
        end
        S_COMPARE: begin
          if (timer_done) begin
            state <= S_EXPIRED;
            {otp_valid, unlock, expired, locked} <= flags_of(S_EXPIRED);
          end else if (match) begin
            attempts_left <= ATT_MAX;
            timer         <= UNL_LOAD;
            state         <= S_UNLOCKED;
            {otp_valid, unlock, expired, locked} <= flags_of(S_UNLOCKED);
          end else if (attempts_left <= 4'd1) begin
            attempts_left <= 4'd0;
            timer         <= lock_load;
            state         <= S_LOCKOUT;
            {otp_valid, unlock, expired, locked} <= flags_of(S_LOCKOUT);
          end else begin
            // Retry keeps the running expiry window.
            attempts_left <= attempts_left - 4'd1;
            user_otp_out  <= '0;
            dig_cnt       <= '0;
            timer         <= timer - 1'b1;
            state         <= S_ARMED;
          end
        end
        S_UNLOCKED: begin
          if (timer_done) begin
            sys_clr <= 1'b1;
            state   <= S_IDLE;
            {otp_valid, unlock, expired, locked} <= flags_of(S_IDLE);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_LOCKOUT: begin
          if (timer_done) begin
            sys_clr       <= 1'b1;
            attempts_left <= ATT_MAX;
            state         <= S_IDLE;
            {otp_valid, unlock, expired, locked} <= flags_of(S_IDLE);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          {otp_valid, unlock, expired, locked} <= flags_of(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otp_session_ctrl.sv
// Directed bench for otp_session_ctrl: unlock, retry, lockout, expiry race, held latch, async reset, optional backoff.
module tb_otp_session_ctrl;

  localparam int E = 100;
  localparam int M = 3;
  localparam int L = 20;
  localparam int U = 10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARMED    = 3'd1;
  localparam logic [2:0] ST_UNLOCKED = 3'd3;
  localparam logic [2:0] ST_LOCKOUT  = 3'd4;
  localparam logic [2:0] ST_EXPIRED  = 3'd5;

  // Flag vectors {otp_valid, unlock, expired, locked}
  localparam logic [3:0] F_NONE   = 4'b0000;
  localparam logic [3:0] F_VALID  = 4'b1000;
  localparam logic [3:0] F_UNLOCK = 4'b0100;
  localparam logic [3:0] F_EXP    = 4'b0010;
  localparam logic [3:0] F_LOCK   = 4'b0001;

  logic        clk;
  logic        reset;
  logic [15:0] lfsr_word;
  logic        otp_req;
  logic [3:0]  user_digit;
  logic        user_latch;
  logic [15:0] otp_out;
  logic [15:0] user_otp_out;
  logic        otp_valid;
  logic        unlock;
  logic        expired;
  logic        locked;
  logic [3:0]  attempts_left;
  logic        sys_clr;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  otp_session_ctrl #(
    .EXPIRY_CYCLES (E),
    .MAX_ATTEMPTS  (M),
    .LOCKOUT_CYCLES(L),
    .UNLOCK_CYCLES (U)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .lfsr_word    (lfsr_word),
    .otp_req      (otp_req),
    .user_digit   (user_digit),
    .user_latch   (user_latch),
    .otp_out      (otp_out),
    .user_otp_out (user_otp_out),
    .otp_valid    (otp_valid),
    .unlock       (unlock),
    .expired      (expired),
    .locked       (locked),
    .attempts_left(attempts_left),
    .sys_clr      (sys_clr),
    .state_dbg    (state_dbg)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, otp_valid, unlock, expired, locked}, {28'd0, exp});
  endtask

  task automatic press_req(input logic [15:0] w);
    lfsr_word = w;
    otp_req   = 1'b1;
    step(1);
    otp_req   = 1'b0;
    step(1);
  endtask

  task automatic enter_digit(input logic [3:0] d);
    user_digit = d;
    user_latch = 1'b1;
    step(1);
    user_latch = 1'b0;
    step(1);
  endtask

  task automatic enter_word(input logic [15:0] w);
    enter_digit(w[15:12]);
    enter_digit(w[11:8]);
    enter_digit(w[7:4]);
    enter_digit(w[3:0]);
  endtask

`ifdef LOCKOUT_BACKOFF_EN
  task automatic lockout_run(input int dur, input string tag);
    press_req(16'hC0DE);
    enter_word(16'h0000);
    enter_word(16'h0000);
    enter_word(16'h0000);
    check({tag, "_on"}, {31'd0, locked}, 32'd1);
    step(dur - 1);
    check({tag, "_hold"}, {31'd0, locked}, 32'd1);
    step(1);
    check({tag, "_off"}, {31'd0, locked}, 32'd0);
    check({tag, "_clr"}, {31'd0, sys_clr}, 32'd1);
  endtask
`endif

  initial begin
    reset      = 1'b0;
    lfsr_word  = 16'h0000;
    otp_req    = 1'b0;
    user_digit = 4'h0;
    user_latch = 1'b0;
    step(2);

    // Reset values
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_otp", otp_out, 16'h0000);
    check("rst_entry", user_otp_out, 16'h0000);
    check_flags("rst_flags", F_NONE);
    check("rst_att", attempts_left, M);
    check("rst_clr", sys_clr, 0);
    reset = 1'b1;
    step(2);

    // 1: correct entry unlocks for U cycles, then sys_clr
    press_req(16'hA5C3);
    check("t1_otp", otp_out, 16'hA5C3);
    check_flags("t1_armed", F_VALID);
    check("t1_state", state_dbg, ST_ARMED);
    enter_word(16'hA5C3);
    check("t1_entry", user_otp_out, 16'hA5C3);
    check_flags("t1_unlock", F_UNLOCK);
    check("t1_att", attempts_left, 3);
    step(U - 1);
    check_flags("t1_unlock_hold", F_UNLOCK);
    check("t1_state_hold", state_dbg, ST_UNLOCKED);
    step(1);
    check_flags("t1_unlock_end", F_NONE);
    check("t1_sysclr", sys_clr, 1);
    check("t1_idle", state_dbg, ST_IDLE);
    step(1);
    check("t1_sysclr_pulse", sys_clr, 0);
    check("t1_otp_hold", otp_out, 16'hA5C3);
    enter_digit(4'h7);
    check("t1_idle_latch_ign", user_otp_out, 16'hA5C3);
    check("t1_idle_stays", state_dbg, ST_IDLE);

    // 2: wrong entry costs one attempt and clears the entry, then correct entry
    press_req(16'h1234);
    enter_word(16'h1235);
    check("t2_att", attempts_left, 2);
    check("t2_entry_clr", user_otp_out, 16'h0000);
    check_flags("t2_valid", F_VALID);
    enter_word(16'h1234);
    check_flags("t2_unlock", F_UNLOCK);
    check("t2_att_reload", attempts_left, 3);
    step(U);
    check("t2_idle", state_dbg, ST_IDLE);

    // 3: three wrong entries -> lockout; otp_req ignored meanwhile
    press_req(16'hBEEF);
    enter_word(16'h0000);
    check("t3_att2", attempts_left, 2);
    enter_word(16'h0001);
    check("t3_att1", attempts_left, 1);
    enter_word(16'h0002);
    check_flags("t3_locked", F_LOCK);
    check("t3_att0", attempts_left, 0);
    press_req(16'h1111);
    check_flags("t3_req_ign", F_LOCK);
    check("t3_otp_kept", otp_out, 16'hBEEF);
    step(L - 3);
    check("t3_lock_hold", state_dbg, ST_LOCKOUT);
    step(1);
    check_flags("t3_lock_end", F_NONE);
    check("t3_sysclr", sys_clr, 1);
    check("t3_att_reload", attempts_left, 3);
    check("t3_idle", state_dbg, ST_IDLE);
    step(1);
    check("t3_sysclr_pulse", sys_clr, 0);

    // 4: expiry exactly E cycles after capture, racing the 4th digit
    press_req(16'h0F0F);
    enter_word(16'h1111);
    check("t4_att2", attempts_left, 2);
    enter_digit(4'h0);
    enter_digit(4'hF);
    enter_digit(4'h0);
    step(E - 16);
    check_flags("t4_not_yet", F_VALID);
    user_digit = 4'hF;
    user_latch = 1'b1;
    step(1);
    user_latch = 1'b0;
    check_flags("t4_expired", F_EXP);
    check("t4_state", state_dbg, ST_EXPIRED);
    step(3);
    check_flags("t4_no_unlock", F_EXP);
    check("t4_att_kept", attempts_left, 2);
    press_req(16'h7777);
    check_flags("t4_rearmed", F_VALID);
    check("t4_otp", otp_out, 16'h7777);
    check("t4_entry_clr", user_otp_out, 16'h0000);
    check("t4_att_still", attempts_left, 2);

    // 5: held latch counts once; async reset mid-entry; high input at release is no edge
    user_digit = 4'h9;
    user_latch = 1'b1;
    step(50);
    user_latch = 1'b0;
    step(1);
    check("t5_one_digit", user_otp_out, 16'h0009);
    enter_digit(4'h8);
    check("t5_second_digit", user_otp_out, 16'h0098);
    check("t5_armed", state_dbg, ST_ARMED);
    reset = 1'b0;
    #1;
    check("t5_rst_otp", otp_out, 16'h0000);
    check("t5_rst_entry", user_otp_out, 16'h0000);
    check_flags("t5_rst_flags", F_NONE);
    check("t5_rst_att", attempts_left, 3);
    check("t5_rst_state", state_dbg, ST_IDLE);
    otp_req = 1'b1;
    step(2);
    reset = 1'b1;
    step(3);
    check("t5_held_req_ign", state_dbg, ST_IDLE);
    otp_req = 1'b0;
    step(1);
    press_req(16'h2222);
    check("t5_capture", otp_out, 16'h2222);

`ifdef LOCKOUT_BACKOFF_EN
    // 6: consecutive lockouts back off, unlock clears the backoff
    lockout_run(L, "t6a");
    lockout_run(2 * L, "t6b");
    lockout_run(4 * L, "t6c");
    press_req(16'h5A5A);
    enter_word(16'h5A5A);
    check_flags("t6_unlock", F_UNLOCK);
    step(U);
    lockout_run(L, "t6d");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
